sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Round-robin arbiter that shares the single-port 32x16 SRAM between up to four requesters, such as the block-processing datapath, a preload/loader engine and a debug reader. It sits between the requesters and the SRAM port driven by TOP. It owns the SRAM command signals (Address, ReadEnable, WriteEnable, DataIN) and returns read data from DataOut to the requester whose read was issued.

## Interface
Parameters:
- NREQ, 2: number of requesters; legal range 2..4.
- AW, 5: SRAM address width (32 words).
- DW, 16: SRAM data width.

Ports:
- Clock  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  synchronous reset, active-high.
- Req  in  NREQ  per-requester request; held high until granted.
- We  in  NREQ  per-requester write select (1 = write, 0 = read); valid while Req is high.
- Addr  in  NREQ*AW  packed addresses; requester k occupies bits [k*AW +: AW].
- Wdata  in  NREQ*DW  packed write data; requester k occupies bits [k*DW +: DW].
- Gnt  out  NREQ  one-hot, combinational; high in the cycle a request is accepted.
- Rvalid  out  NREQ  one-hot, registered; high in the cycle read data is returned.
- Rdata  out  DW  read data, shared by all requesters; meaningful only while some Rvalid bit is high.
- Address  out  AW  registered SRAM address.
- ReadEnable  out  1  registered SRAM read strobe.
- WriteEnable  out  1  registered SRAM write strobe.
- DataIN  out  DW  registered data to the SRAM.
- DataOut  in  DW  SRAM read data; valid in the cycle after the SRAM samples ReadEnable.

## Operation
- Arbitration:
  - Among the high Req bits, the winner is the first one found searching upward (with wrap-around) from rr_ptr+1.
  - Gnt[winner] is high in that same cycle. All other Gnt bits are 0.
  - If no Req bit is high, Gnt = 0.
- rr_ptr update:
  - On each grant, rr_ptr <= winner.
  - If there is no grant, rr_ptr holds.
  - Reset value is NREQ-1, so requester 0 has highest priority after reset.
- Command register: on the edge that closes a grant cycle, the arbiter loads:
  - Address <= Addr[winner];
  - DataIN <= Wdata[winner];
  - WriteEnable <= We[winner];
  - ReadEnable <= ~We[winner].
  - With no grant, both strobes go to 0, and Address and DataIN hold their values.
- Read return:
  - A read tag (valid bit plus requester index) is pipelined for two stages alongside each read command.
  - Rvalid[tag] is high when the tag leaves the second stage.
  - Rdata is DataOut passed through combinationally.
- Requester rule: Req, We, Addr and Wdata must be stable from the rise of Req until the Gnt cycle. A requester may present its next request in the cycle after Gnt.
- Throughput is one access per cycle in total. Each requester with a continuous Req is served at least once every NREQ cycles.
- Reads and writes from different requesters may be interleaved back to back. The SRAM completes them in issue order.
- Reset mid-operation:
  - Gnt, all strobes and Rvalid drop to 0 on the reset edge.
  - Any read in flight is discarded; no Rvalid is ever issued for it.
- Reset values: ReadEnable, WriteEnable, Rvalid, Address and DataIN are all 0. Gnt is 0 during reset regardless of Req.

## Timing
- Cycle t: Req high and the requester wins, so Gnt is high in t.
- Cycle t+1: the SRAM command is visible on Address, ReadEnable and WriteEnable. The SRAM samples it on the edge ending t+1.
- Cycle t+2: for a read, Rvalid[k] is high and Rdata = DataOut. Read latency is 2 cycles from Gnt.
- Write: the SRAM is updated on the edge ending t+1. A read of the same address granted in t+1 returns the new value.
- Simultaneous Req in the same cycle: exactly one Gnt; the losers keep Req high and remain pending.

## Configuration
- SRAM_ARB_LOCK_EN defined:
  - Adds input Lock [NREQ-1:0].
  - If the current owner (rr_ptr) has Lock high and Req high, it wins unconditionally. This gives uninterrupted bursts, e.g. an 8-word block scan.
  - A lock is ignored in the cycle the owner's Req is low, and arbitration resumes.
  - Reset clears ownership.
- SRAM_ARB_LOCK_EN undefined:
  - No Lock port.
  - Pure round-robin arbitration.

## Structure
- Shared package sram_pkg holds:
  - SRAM_AW = 5 and SRAM_DW = 16;
  - the result-address constants (7, 15, 23, 31);
  - the request-tag record type (valid bit plus requester index).
- One sub-module, rr_pick:
  - Combinational round-robin priority selector.
  - Inputs are the Req vector and rr_ptr. Outputs are the one-hot Gnt vector and the winner index.
- Everything else (command register, tag pipeline, pointer, lock) lives in sram_arbiter.

## Test plan
- Single read: SRAM preloaded with sram[7]=16'h1234; requester 0 reads address 7.
  - Expected: Gnt[0] in cycle t, ReadEnable=1 with Address=7 in t+1, Rvalid[0]=1 with Rdata=16'h1234 in t+2.
- Write then read: requester 1 writes 16'hBEEF to address 31, and requester 0 reads 31 in the next cycle.
  - Expected: Rdata=16'hBEEF, and sram[31]=16'hBEEF afterwards.
- Contention: Req=4'b1111 held with NREQ=4.
  - Expected: the Gnt sequence is 0001, 0010, 0100, 1000, 0001 (no requester starves), and ReadEnable is high every cycle.
- Reset mid-read: Reset is asserted in cycle t+1 of a read.
  - Expected: no Rvalid in t+2, all outputs 0, and the first grant after reset goes to requester 0.
- Lock (SRAM_ARB_LOCK_EN): requester 0 reads addresses 0..7 with Lock[0]=1 while Req[1] is held high.
  - Expected: 8 consecutive Gnt[0] cycles, then Gnt[1].
- Idle: Req=0 for 10 cycles.
  - Expected: ReadEnable, WriteEnable, Gnt and Rvalid all stay 0, and Address is unchanged.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared SRAM constants and the read-tag record used by sram_arbiter.
package sram_pkg;

    localparam int SRAM_AW = 5;
    localparam int SRAM_DW = 16;
    localparam int TAG_IW  = 2;

    // Block-result word addresses in the 32x16 SRAM.
    localparam logic [SRAM_AW-1:0] RES_ADDR0 = 5'd7;
    localparam logic [SRAM_AW-1:0] RES_ADDR1 = 5'd15;
    localparam logic [SRAM_AW-1:0] RES_ADDR2 = 5'd23;
    localparam logic [SRAM_AW-1:0] RES_ADDR3 = 5'd31;

    typedef struct packed {
        logic              vld;
        logic [TAG_IW-1:0] idx;
    } req_tag_t;

endpackage

// File: rtl/sram_arbiter_rr_pick.sv
// Combinational round-robin selector: first high request found searching upward from ptr+1.
module rr_pick
    import sram_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]   req,
    input  logic [TAG_IW-1:0] ptr,
    output logic [NREQ-1:0]   gnt,
    output logic [TAG_IW-1:0] winner,
    output logic              found
);

    always_comb begin
        gnt    = '0;
        winner = ptr;
        found  = 1'b0;
        // Offset i picks exactly one j, so the outer loop order sets priority.
        for (int i = 1; i <= NREQ; i++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!found && req[j] && ((int'(ptr) + i) % NREQ) == j) begin
                    found  = 1'b1;
                    gnt[j] = 1'b1;
                    winner = TAG_IW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one 32x16 single-port SRAM among NREQ requesters.
// Optional SRAM_ARB_LOCK_EN adds a Lock input that lets the current owner burst.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = SRAM_AW,
    parameter int DW   = SRAM_DW
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [NREQ-1:0]   Req,
    input  logic [NREQ-1:0]   We,
    input  logic [NREQ*AW-1:0] Addr,
    input  logic [NREQ*DW-1:0] Wdata,
`ifdef SRAM_ARB_LOCK_EN
    input  logic [NREQ-1:0]   Lock,
`endif
    output logic [NREQ-1:0]   Gnt,
    output logic [NREQ-1:0]   Rvalid,
    output logic [DW-1:0]     Rdata,
    output logic [AW-1:0]     Address,
    output logic              ReadEnable,
    output logic              WriteEnable,
    output logic [DW-1:0]     DataIN,
    input  logic [DW-1:0]     DataOut
);

    logic [TAG_IW-1:0] rr_ptr;
    logic [NREQ-1:0]   pick_gnt;
    logic [TAG_IW-1:0] pick_idx;
    logic              pick_found;

    logic [NREQ-1:0]   gnt_p0;
    logic [TAG_IW-1:0] win_p0;
    logic              vld_p0;
    logic [AW-1:0]     sel_addr;
    logic [DW-1:0]     sel_wdata;
    logic              sel_we;

    req_tag_t tag_p1;
    req_tag_t tag_p2;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (Req),
        .ptr    (rr_ptr),
        .gnt    (pick_gnt),
        .winner (pick_idx),
        .found  (pick_found)
    );

`ifdef SRAM_ARB_LOCK_EN
    logic            owned;
    logic [NREQ-1:0] ptr_oh;

    always_ff @(posedge Clock) begin
        if (Reset)
            owned <= 1'b0;
        else if (vld_p0)
            owned <= 1'b1;
    end
`endif

    // Stage p0: arbitration and winner operand select
    always_comb begin
        gnt_p0 = pick_gnt;
        win_p0 = pick_idx;
        vld_p0 = pick_found;
`ifdef SRAM_ARB_LOCK_EN
        for (int i = 0; i < NREQ; i++)
            ptr_oh[i] = (rr_ptr == TAG_IW'(i));
        if (owned && |(ptr_oh & Lock & Req)) begin
            gnt_p0 = ptr_oh;
            win_p0 = rr_ptr;
            vld_p0 = 1'b1;
        end
`endif
        if (Reset) begin
            gnt_p0 = '0;
            vld_p0 = 1'b0;
        end
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_p0 == TAG_IW'(i)) begin
                sel_addr  = Addr[i*AW +: AW];
                sel_wdata = Wdata[i*DW +: DW];
                sel_we    = We[i];
            end
        end
    end

    assign Gnt = gnt_p0;

    // Stage p1: SRAM command register and first read-tag stage
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rr_ptr      <= TAG_IW'(NREQ - 1);
            Address     <= '0;
            DataIN      <= '0;
            ReadEnable  <= 1'b0;
            WriteEnable <= 1'b0;
            tag_p1      <= '0;
        end else if (vld_p0) begin
            rr_ptr      <= win_p0;
            Address     <= sel_addr;
            DataIN      <= sel_wdata;
            ReadEnable  <= ~sel_we;
            WriteEnable <= sel_we;
            tag_p1      <= '{vld: ~sel_we, idx: win_p0};
        end else begin
            ReadEnable  <= 1'b0;
            WriteEnable <= 1'b0;
            tag_p1      <= '0;
        end
    end

    // Stage p2: tag aligned with SRAM read data
    always_ff @(posedge Clock) begin
        if (Reset)
            tag_p2 <= '0;
        else
            tag_p2 <= tag_p1;
    end

    always_comb begin
        Rvalid = '0;
        for (int i = 0; i < NREQ; i++)
            Rvalid[i] = tag_p2.vld && (tag_p2.idx == TAG_IW'(i));
    end

    assign Rdata = DataOut;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with NREQ=4 and a behavioural 32x16 SRAM.
module tb_sram_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 5;
    localparam int DW   = 16;

    logic              Clock = 1'b0;
    logic              Reset;
    logic [NREQ-1:0]   Req;
    logic [NREQ-1:0]   We;
    logic [NREQ*AW-1:0] Addr;
    logic [NREQ*DW-1:0] Wdata;
    logic [NREQ-1:0]   Lock;
    logic [NREQ-1:0]   Gnt;
    logic [NREQ-1:0]   Rvalid;
    logic [DW-1:0]     Rdata;
    logic [AW-1:0]     Address;
    logic              ReadEnable;
    logic              WriteEnable;
    logic [DW-1:0]     DataIN;
    logic [DW-1:0]     DataOut;

    logic [DW-1:0] mem [32];

    typedef struct {
        int          idx;
        logic [15:0] data;
    } exp_t;
    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    always #5 Clock = ~Clock;

    sram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Req         (Req),
        .We          (We),
        .Addr        (Addr),
        .Wdata       (Wdata),
`ifdef SRAM_ARB_LOCK_EN
        .Lock        (Lock),
`endif
        .Gnt         (Gnt),
        .Rvalid      (Rvalid),
        .Rdata       (Rdata),
        .Address     (Address),
        .ReadEnable  (ReadEnable),
        .WriteEnable (WriteEnable),
        .DataIN      (DataIN),
        .DataOut     (DataOut)
    );

    // Behavioural SRAM: registered read, write on the same edge.
    always @(posedge Clock) begin
        if (WriteEnable) mem[Address] <= DataIN;
        if (ReadEnable)  DataOut <= mem[Address];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
        end
    endtask

    task automatic set_port(input int k, input logic we_v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        We[k]            = we_v;
        Addr[k*AW +: AW] = a;
        Wdata[k*DW +: DW] = d;
    endtask

    task automatic push(input int k, input logic [15:0] d);
        exp_t e;
        e.idx  = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge Clock);
        #1;
    endtask

    // Monitor: every returned read is matched against the oldest expected read.
    always @(negedge Clock) begin
        if (Rvalid != '0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rvalid actual=%0h required=0", Rvalid);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rvalid_onehot", 32'(Rvalid), 32'(1) << e.idx);
                chk("rdata", 32'(Rdata), 32'(e.data));
            end
        end
    end

    logic [3:0]  cont_gnt  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [15:0] cont_data [5] = '{16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA001};

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 16'hA000 + 16'(i);
        mem[7] = 16'h1234;
        DataOut = '0;
        Reset = 1'b1;
        Req   = '1;
        We    = '0;
        Addr  = '0;
        Wdata = '0;
        Lock  = '0;

        // Reset state, with requests pending during reset
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        chk("reset_gnt", 32'(Gnt), 0);
        chk("reset_re", 32'(ReadEnable), 0);
        chk("reset_we", 32'(WriteEnable), 0);
        chk("reset_rvalid", 32'(Rvalid), 0);
        chk("reset_address", 32'(Address), 0);
        chk("reset_datain", 32'(DataIN), 0);
        next_cycle();
        Reset = 1'b0;
        Req   = '0;
        next_cycle();

        // Single read of address 7 by requester 0
        set_port(0, 1'b0, 5'd7, 16'h0);
        Req = 4'b0001;
        @(negedge Clock);
        chk("single_gnt", 32'(Gnt), 32'b0001);
        push(0, 16'h1234);
        next_cycle();
        Req = '0;
        @(negedge Clock);
        chk("single_re", 32'(ReadEnable), 1);
        chk("single_we", 32'(WriteEnable), 0);
        chk("single_addr", 32'(Address), 7);
        next_cycle();
        next_cycle();

        // Requester 1 writes 31, requester 0 reads it back-to-back
        set_port(1, 1'b1, 5'd31, 16'hBEEF);
        Req = 4'b0010;
        @(negedge Clock);
        chk("wr_gnt", 32'(Gnt), 32'b0010);
        next_cycle();
        set_port(0, 1'b0, 5'd31, 16'h0);
        Req = 4'b0001;
        @(negedge Clock);
        chk("rd_after_wr_gnt", 32'(Gnt), 32'b0001);
        chk("wr_strobe", 32'(WriteEnable), 1);
        chk("wr_addr", 32'(Address), 31);
        chk("wr_data", 32'(DataIN), 32'hBEEF);
        push(0, 16'hBEEF);
        next_cycle();
        Req = '0;
        We  = '0;
        @(negedge Clock);
        chk("rd_after_wr_re", 32'(ReadEnable), 1);
        next_cycle();
        next_cycle();
        chk("mem31", 32'(mem[31]), 32'hBEEF);

        // Reset asserted in t+1 of a read by requester 2
        set_port(2, 1'b0, 5'd15, 16'h0);
        Req = 4'b0100;
        @(negedge Clock);
        chk("midrd_gnt", 32'(Gnt), 32'b0100);
        next_cycle();
        Reset = 1'b1;
        for (int k = 0; k < NREQ; k++) set_port(k, 1'b0, 5'(k + 1), 16'h0);
        Req = 4'b1111;
        @(negedge Clock);
        chk("midrd_gnt_in_reset", 32'(Gnt), 0);
        next_cycle();
        Reset = 1'b0;

        // Contention: all four held after reset
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            if (i == 0) begin
                chk("postrst_rvalid", 32'(Rvalid), 0);
                chk("postrst_re", 32'(ReadEnable), 0);
                chk("postrst_address", 32'(Address), 0);
            end else begin
                chk("cont_re", 32'(ReadEnable), 1);
            end
            chk($sformatf("cont_gnt%0d", i), 32'(Gnt), 32'(cont_gnt[i]));
            push($clog2(int'(cont_gnt[i])), cont_data[i]);
            next_cycle();
        end
        Req = '0;

        // Idle for 10 cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            chk("idle_gnt", 32'(Gnt), 0);
            if (i >= 1) begin
                chk("idle_re", 32'(ReadEnable), 0);
                chk("idle_we", 32'(WriteEnable), 0);
                chk("idle_address", 32'(Address), 1);
            end
            if (i >= 2) chk("idle_rvalid", 32'(Rvalid), 0);
            next_cycle();
        end

`ifdef SRAM_ARB_LOCK_EN
        // Locked 8-word burst by requester 0 while requester 1 waits
        set_port(0, 1'b0, 5'd0, 16'h0);
        set_port(1, 1'b0, 5'd2, 16'h0);
        Lock = 4'b0001;
        Req  = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            chk($sformatf("lock_gnt%0d", i), 32'(Gnt), 32'b0001);
            push(0, (i == 7) ? 16'h1234 : 16'hA000 + 16'(i));
            next_cycle();
            if (i < 7) begin
                Addr[0 +: AW] = 5'(i + 1);
            end else begin
                Req  = 4'b0010;
                Lock = '0;
            end
        end
        @(negedge Clock);
        chk("lock_release_gnt", 32'(Gnt), 32'b0010);
        push(1, 16'hA002);
        next_cycle();
        Req = '0;
        repeat (4) next_cycle();
`endif

        repeat (3) next_cycle();
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
